// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state encodings, lane count and judge FSM states
package game_pkg;

  // Top-level game FSM encoding, shared with the score counter
  typedef enum logic [1:0] {
    GS_IDLE        = 2'd0,
    GS_SONG_SELECT = 2'd1,
    GS_GAME_PLAY   = 2'd2,
    GS_GAME_OVER   = 2'd3
  } game_state_e;

  localparam int LANES = 2;

  // Note judge FSM states
  typedef enum logic [1:0] {
    J_IDLE   = 2'd0,
    J_WAIT   = 2'd1,
    J_WINDOW = 2'd2,
    J_JUDGE  = 2'd3
  } judge_state_e;

  // Increment that sticks at the limit instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchroniser plus rising-edge pulse for one lane button
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the raw button and keep one extra stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Pulse only for the first synchronised cycle of a press
  assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/note_judge.sv
// rtl/note_judge.sv - per-beat lane hit judgement with running and best combo
module note_judge
  import game_pkg::*;
#(
  parameter int         WINDOW_CYC = 2_500_000,
  parameter int         CNT_W      = 22,
  parameter logic [7:0] COMBO_MAX  = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       current_state,
  input  logic             beat_tick,
  input  logic [LANES-1:0] note_req,
  input  logic [LANES-1:0] btn,
  output logic             judge_valid,
  output logic [LANES-1:0] judge_hit,
  output logic [7:0]       combo,
  output logic [7:0]       max_combo,
  output logic             window_open
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_CYC - 1);

  logic [LANES-1:0] press;

  judge_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] req_q, req_d;
  logic [LANES-1:0] hit_q, hit_d;
  logic             jv_q, jv_d;
  logic [LANES-1:0] jh_q, jh_d;
  logic [7:0]       combo_q, combo_d;
  logic [7:0]       max_q, max_d;
  logic             wo_q, wo_d;
  logic [LANES-1:0] hit_now;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    btn_edge u_edge (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn[i]),
      .press_o (press[i])
    );
  end

  // State, window and score registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= J_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hit_q   <= '0;
      jv_q    <= 1'b0;
      jh_q    <= '0;
      combo_q <= 8'd0;
      max_q   <= 8'd0;
      wo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hit_q   <= hit_d;
      jv_q    <= jv_d;
      jh_q    <= jh_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      wo_q    <= wo_d;
    end
  end

  // Next state: open windows on beats, collect presses, judge at window close.
  // In JUDGE, a non-zero req_q means a beat arrived during the early close and
  // its window still has to run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hit_d   = hit_q;
    jv_d    = 1'b0;
    jh_d    = '0;
    combo_d = combo_q;
    max_d   = max_q;
    hit_now = hit_q | (press & req_q);

    if (current_state != GS_GAME_PLAY) begin
      state_d = J_IDLE;
      cnt_d   = '0;
      req_d   = '0;
      hit_d   = '0;
      if (current_state == GS_SONG_SELECT) begin
        combo_d = 8'd0;
        max_d   = 8'd0;
      end
    end else begin
      case (state_q)
        J_IDLE: state_d = J_WAIT;
        J_WAIT: begin
          if (beat_tick && (note_req != '0)) begin
            state_d = J_WINDOW;
            req_d   = note_req;
            hit_d   = '0;
            cnt_d   = '0;
          end
        end
        J_WINDOW: begin
          cnt_d = cnt_q + 1'b1;
          hit_d = hit_now;
          if (beat_tick || (cnt_q == CNT_LAST)) begin
            state_d = J_JUDGE;
            jv_d    = 1'b1;
            jh_d    = hit_now;
            combo_d = (hit_now == req_q) ? sat_inc(combo_q, COMBO_MAX) : 8'd0;
            max_d   = (combo_d > max_q) ? combo_d : max_q;
            req_d   = beat_tick ? note_req : '0;
            hit_d   = '0;
            cnt_d   = '0;
          end
        end
        J_JUDGE: begin
          hit_d = '0;
          cnt_d = '0;
          if (beat_tick && (note_req != '0)) begin
            state_d = J_WINDOW;
            req_d   = note_req;
          end else if (req_q != '0) begin
            state_d = J_WINDOW;
          end else begin
            state_d = J_WAIT;
          end
        end
        default: state_d = J_IDLE;
      endcase
    end

    wo_d = (state_d == J_WINDOW);
  end

  assign judge_valid = jv_q;
  assign judge_hit   = jh_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign window_open = wo_q;

endmodule
